// File: rtl/rect_swap_engine.sv
// -----------------------------------------------------------------------------
// rect_swap_engine
//
// Sequential checkerboard-swap core for a ROWS x COLS binary matrix. A run
// loads mat_in, then performs num_swaps attempts. Each attempt draws two
// distinct rows and two distinct columns from a 32-bit Galois LFSR. If the
// four corners form a checkerboard, all four bits flip, so every row and
// column sum is preserved.
//
// Optional feature macro: RECT_SWAP_STATS_EN
//   defined   : swap_cnt counts successful swaps (saturating), and an internal
//               saturating rejected-draw counter r_rej_cnt is kept.
//   undefined : swap_cnt is tied to 0 and both counters are absent.
//   Matrix behaviour and timing are identical in both builds.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   start      in   begin a run (sampled only in IDLE)
//   num_swaps  in   attempts for the run (0 -> straight to DONE)
//   seed_load  in   load seed into the LFSR (IDLE only, 0 becomes 1)
//   seed       in   LFSR load value
//   mat_in     in   input matrix, row-major, bit r*COLS+c is M[r][c]
//   mat_out    out  working matrix register, same packing
//   busy       out  high in PICK and CHECK
//   done       out  one-cycle pulse at the end of a run
//   swap_cnt   out  successful swaps in the last or current run
// -----------------------------------------------------------------------------
module rect_swap_engine #(
  parameter int          ROWS  = 4,
  parameter int          COLS  = 4,
  parameter int          CNT_W = 12,
  parameter logic [31:0] SEED  = 32'h1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_swaps,
  input  logic                 seed_load,
  input  logic [31:0]          seed,
  input  logic [ROWS*COLS-1:0] mat_in,
  output logic [ROWS*COLS-1:0] mat_out,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     swap_cnt
);

  localparam int          RW        = $clog2(ROWS);
  localparam int          CW        = $clog2(COLS);
  localparam int          N         = ROWS * COLS;
  localparam int          IW        = $clog2(N);
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;

  // Four index fields must fit in one LFSR word.
  generate
    if (ROWS < 2 || ROWS > 256 || COLS < 2 || COLS > 256 || 2 * (RW + CW) > 32) begin : g_bad_cfg
      $error("rect_swap_engine: unsupported ROWS/COLS combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_PICK,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [N-1:0]     r_mat;
  logic [31:0]      r_lfsr;
  logic [31:0]      w_lfsr_nx;
  logic [CNT_W-1:0] r_left;
  logic [RW-1:0]    r_r1, r_r2;
  logic [CW-1:0]    r_c1, r_c2;

  // Candidate draw from the current LFSR value.
  logic [RW-1:0]    w_r1, w_r2;
  logic [CW-1:0]    w_c1, w_c2;
  logic             w_draw_ok;

  // Corner addresses and values of the latched rectangle.
  logic [IW-1:0]    w_i11, w_i12, w_i21, w_i22;
  logic             w_m11, w_m12, w_m21, w_m22;
  logic             w_swap;

  assign w_r1 = r_lfsr[RW-1:0];
  assign w_c1 = r_lfsr[RW+CW-1:RW];
  assign w_r2 = r_lfsr[2*RW+CW-1:RW+CW];
  assign w_c2 = r_lfsr[2*RW+2*CW-1:2*RW+CW];

  // Indices are widened to 32 bits so out-of-range codes compare correctly
  // when ROWS/COLS are not powers of two.
  assign w_draw_ok = (32'(w_r1) < ROWS) && (32'(w_r2) < ROWS) &&
                     (32'(w_c1) < COLS) && (32'(w_c2) < COLS) &&
                     (w_r1 != w_r2) && (w_c1 != w_c2);

  // Right-shifting Galois step; the feedback mask includes the x^32 term.
  assign w_lfsr_nx = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_MASK : 32'h0);

  assign w_i11 = IW'(32'(r_r1) * COLS + 32'(r_c1));
  assign w_i12 = IW'(32'(r_r1) * COLS + 32'(r_c2));
  assign w_i21 = IW'(32'(r_r2) * COLS + 32'(r_c1));
  assign w_i22 = IW'(32'(r_r2) * COLS + 32'(r_c2));

  assign w_m11 = r_mat[w_i11];
  assign w_m12 = r_mat[w_i12];
  assign w_m21 = r_mat[w_i21];
  assign w_m22 = r_mat[w_i22];

  // Checkerboard: diagonals equal, and the two diagonals differ.
  assign w_swap = (w_m11 == w_m22) && (w_m12 == w_m21) && (w_m11 != w_m12);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    // NOTE: default assigned first so every path drives w_state_nx; without it
    // the missing branches would infer a latch.
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nx = (num_swaps == '0) ? S_DONE : S_PICK;
      S_PICK:  if (w_draw_ok) w_state_nx = S_CHECK;
      S_CHECK: w_state_nx = (r_left == CNT_W'(1)) ? S_DONE : S_PICK;
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign busy    = (r_state == S_PICK) || (r_state == S_CHECK);
  assign done    = (r_state == S_DONE);
  assign mat_out = r_mat;

  // ---------------------------------------------------------------------------
  // Datapath: matrix, LFSR, attempt counter, latched rectangle
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the matrix register is reset as well: it is the visible mat_out
      // and must read 0 after reset, not whatever the last run left behind.
      r_mat  <= '0;
      r_lfsr <= SEED_EFF;
      r_left <= '0;
      r_r1   <= '0;
      r_r2   <= '0;
      r_c1   <= '0;
      r_c2   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          // Seed load and start in the same cycle: the run sees the new seed
          // because the LFSR first advances in PICK.
          if (seed_load) r_lfsr <= (seed == 32'h0) ? 32'h1 : seed;
          if (start) begin
            r_mat  <= mat_in;
            r_left <= num_swaps;
          end
        end
        S_PICK: begin
          r_lfsr <= w_lfsr_nx;
          if (w_draw_ok) begin
            r_r1 <= w_r1;
            r_r2 <= w_r2;
            r_c1 <= w_c1;
            r_c2 <= w_c2;
          end
        end
        S_CHECK: begin
          r_left <= r_left - CNT_W'(1);
          if (w_swap) begin
            r_mat[w_i11] <= ~w_m11;
            r_mat[w_i12] <= ~w_m12;
            r_mat[w_i21] <= ~w_m21;
            r_mat[w_i22] <= ~w_m22;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Optional statistics
  // ---------------------------------------------------------------------------
`ifdef RECT_SWAP_STATS_EN
  logic [CNT_W-1:0] r_swap_cnt;
  logic [CNT_W-1:0] r_rej_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_swap_cnt <= '0;
      r_rej_cnt  <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_swap_cnt <= '0;
        r_rej_cnt  <= '0;
      end
      if (r_state == S_CHECK && w_swap && r_swap_cnt != '1)
        r_swap_cnt <= r_swap_cnt + CNT_W'(1);
      if (r_state == S_PICK && !w_draw_ok && r_rej_cnt != '1)
        r_rej_cnt <= r_rej_cnt + CNT_W'(1);
    end
  end

  assign swap_cnt = r_swap_cnt;
`else
  assign swap_cnt = '0;
`endif

endmodule

// File: tb/tb_rect_swap_engine.sv
// -----------------------------------------------------------------------------
// tb_rect_swap_engine
//
// Three engines (2x2, 4x4, 3x5) share clock and reset. Each run is predicted
// by a behavioural model that replays the draw/accept/flip rules on a 2-D bit
// array and yields the final matrix, swap count and exact run length.
// -----------------------------------------------------------------------------
module tb_rect_swap_engine;

`ifdef RECT_SWAP_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clk;
  logic        rst;
  logic [2:0]  start_v;
  logic [2:0]  seed_load_v;
  logic [11:0] num_swaps [3];
  logic [31:0] seed      [3];
  logic [24:0] mat_in    [3];
  wire  [2:0]  busy_v;
  wire  [2:0]  done_v;
  wire  [3:0]  mo0;
  wire  [15:0] mo1;
  wire  [14:0] mo2;
  wire  [11:0] sc0, sc1, sc2;

  int          errors;
  int          checks;
  logic [31:0] model_lfsr [3];
  logic [24:0] last_m;
  int          last_cnt;

  rect_swap_engine #(.ROWS(2), .COLS(2), .CNT_W(12), .SEED(32'h1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .num_swaps(num_swaps[0]),
    .seed_load(seed_load_v[0]), .seed(seed[0]), .mat_in(mat_in[0][3:0]),
    .mat_out(mo0), .busy(busy_v[0]), .done(done_v[0]), .swap_cnt(sc0));

  rect_swap_engine #(.ROWS(4), .COLS(4), .CNT_W(12), .SEED(32'h5EED)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .num_swaps(num_swaps[1]),
    .seed_load(seed_load_v[1]), .seed(seed[1]), .mat_in(mat_in[1][15:0]),
    .mat_out(mo1), .busy(busy_v[1]), .done(done_v[1]), .swap_cnt(sc1));

  rect_swap_engine #(.ROWS(3), .COLS(5), .CNT_W(12), .SEED(32'h0)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .num_swaps(num_swaps[2]),
    .seed_load(seed_load_v[2]), .seed(seed[2]), .mat_in(mat_in[2][14:0]),
    .mat_out(mo2), .busy(busy_v[2]), .done(done_v[2]), .swap_cnt(sc2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int rows_of(input int k);
    case (k)
      0:       return 2;
      1:       return 4;
      default: return 3;
    endcase
  endfunction

  function automatic int cols_of(input int k);
    case (k)
      0:       return 2;
      1:       return 4;
      default: return 5;
    endcase
  endfunction

  function automatic logic [24:0] mat_of(input int k);
    case (k)
      0:       return 25'(mo0);
      1:       return 25'(mo1);
      default: return 25'(mo2);
    endcase
  endfunction

  function automatic logic [11:0] sc_of(input int k);
    case (k)
      0:       return sc0;
      1:       return sc1;
      default: return sc2;
    endcase
  endfunction

  function automatic logic [24:0] rnd_mat(input int k);
    logic [24:0] mask;
    mask = 25'((64'd1 << (rows_of(k) * cols_of(k))) - 64'd1);
    return 25'($urandom) & mask;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // Reset values of the three LFSRs (SEED 0 becomes 1).
  task automatic reset_model();
    model_lfsr[0] = 32'h1;
    model_lfsr[1] = 32'h5EED;
    model_lfsr[2] = 32'h1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural run: returns final matrix, swaps and PICK+CHECK cycle count.
  task automatic model_run(input int k, input logic [24:0] min, input int n,
                           output logic [24:0] mout, output int swaps, output int cyc);
    int          nr, nc, rw, cw, r1, c1, r2, c2;
    logic [31:0] l, rmask, cmask;
    bit          m [0:7][0:7];
    nr = rows_of(k);
    nc = cols_of(k);
    rw = $clog2(nr);
    cw = $clog2(nc);
    rmask = (32'd1 << rw) - 32'd1;
    cmask = (32'd1 << cw) - 32'd1;
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < nc; c++)
        m[r][c] = min[r*nc+c];
    l = model_lfsr[k];
    swaps = 0;
    cyc = 0;
    for (int a = 0; a < n; a++) begin
      do begin
        r1 = int'(l & rmask);
        c1 = int'((l >> rw) & cmask);
        r2 = int'((l >> (rw + cw)) & rmask);
        c2 = int'((l >> (2 * rw + cw)) & cmask);
        l = lfsr_step(l);
        cyc++;
      end while (r1 >= nr || r2 >= nr || c1 >= nc || c2 >= nc || r1 == r2 || c1 == c2);
      cyc++;
      if (m[r1][c1] == m[r2][c2] && m[r1][c2] == m[r2][c1] && m[r1][c1] != m[r1][c2]) begin
        m[r1][c1] = !m[r1][c1];
        m[r1][c2] = !m[r1][c2];
        m[r2][c1] = !m[r2][c1];
        m[r2][c2] = !m[r2][c2];
        swaps++;
      end
    end
    model_lfsr[k] = l;
    mout = '0;
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < nc; c++)
        mout[r*nc+c] = m[r][c];
  endtask

  task automatic check_idle_reset(input int k, input string tag);
    check({tag, ".mat_out"}, mat_of(k), 0);
    check({tag, ".busy"}, busy_v[k], 0);
    check({tag, ".done"}, done_v[k], 0);
    check({tag, ".swap_cnt"}, sc_of(k), 0);
  endtask

  task automatic check_sums(input int k, input logic [24:0] a, input logic [24:0] b,
                            input string tag);
    int nr, nc, sa, sb, bad;
    nr = rows_of(k);
    nc = cols_of(k);
    bad = 0;
    for (int r = 0; r < nr; r++) begin
      sa = 0; sb = 0;
      for (int c = 0; c < nc; c++) begin
        sa += int'(a[r*nc+c]);
        sb += int'(b[r*nc+c]);
      end
      if (sa != sb) bad++;
    end
    for (int c = 0; c < nc; c++) begin
      sa = 0; sb = 0;
      for (int r = 0; r < nr; r++) begin
        sa += int'(a[r*nc+c]);
        sb += int'(b[r*nc+c]);
      end
      if (sa != sb) bad++;
    end
    check(tag, bad, 0);
  endtask

  // One complete run on engine k; poke pulses start while busy.
  task automatic do_run(input int k, input logic [24:0] min, input int n, input bit ld,
                        input logic [31:0] s, input bit poke, input string tag);
    logic [24:0] exp_m;
    int          exp_sw, exp_cyc, cnt, busy_bad, budget;
    if (ld) model_lfsr[k] = (s == 32'h0) ? 32'h1 : s;
    model_run(k, min, n, exp_m, exp_sw, exp_cyc);
    budget = 40 * n + 100;
    @(negedge clk);
    mat_in[k]      = min;
    num_swaps[k]   = 12'(n);
    seed[k]        = s;
    seed_load_v[k] = ld;
    start_v[k]     = 1'b1;
    @(negedge clk);
    start_v[k]     = 1'b0;
    seed_load_v[k] = 1'b0;
    cnt = 0;
    busy_bad = 0;
    while (done_v[k] !== 1'b1 && cnt < budget) begin
      if (busy_v[k] !== 1'b1) busy_bad++;
      start_v[k] = poke && (cnt == 1);
      @(negedge clk);
      cnt++;
    end
    start_v[k] = 1'b0;
    check({tag, ".done"}, done_v[k], 1);
    check({tag, ".latency"}, cnt, exp_cyc);
    check({tag, ".busy_run"}, busy_bad, 0);
    check({tag, ".busy_at_done"}, busy_v[k], 0);
    check({tag, ".mat"}, mat_of(k), exp_m);
    check({tag, ".swap_cnt"}, sc_of(k), (STATS != 0) ? exp_sw : 0);
    @(negedge clk);
    check({tag, ".after_done"}, {busy_v[k], done_v[k]}, 2'b00);
    check({tag, ".mat_hold"}, mat_of(k), exp_m);
    last_m   = mat_of(k);
    last_cnt = cnt;
  endtask

  initial begin
    logic [24:0] m, first, full_m, tm;
    logic [31:0] s;
    int          tsw, tcyc, cyc1, k;

    errors = 0;
    checks = 0;
    rst = 1'b1;
    start_v = '0;
    seed_load_v = '0;
    for (int i = 0; i < 3; i++) begin
      mat_in[i] = '0;
      num_swaps[i] = '0;
      seed[i] = '0;
    end
    reset_model();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check_idle_reset(i, $sformatf("reset%0d", i));
    rst = 1'b0;

    // SEED parameter 0 must start from LFSR value 1.
    do_run(2, rnd_mat(2), 5, 1'b0, 32'h0, 1'b0, "seed0_param");

    // 2x2 directed: every accepted draw covers the whole matrix.
    do_run(0, 25'b1001, 1, 1'b1, 32'h1, 1'b0, "r2_n1");
    check("r2_n1.const", last_m, 25'b0110);
    do_run(0, 25'b1001, 2, 1'b0, 32'h0, 1'b0, "r2_n2");
    check("r2_n2.const", last_m, 25'b1001);
    do_run(0, 25'b1100, 1, 1'b0, 32'h0, 1'b0, "r2_nochk");
    check("r2_nochk.const", last_m, 25'b1100);
    do_run(0, 25'b1001, 0, 1'b0, 32'h0, 1'b0, "r2_n0");
    check("r2_n0.const", last_m, 25'b1001);

    // All-zero 4x4, 100 attempts, with a start pulse while busy.
    do_run(1, 25'h0, 100, 1'b1, 32'h7, 1'b1, "z100");
    check("z100.min_cycles", (last_cnt + 1) >= 201, 1);

    // Long 4x4 run: sums preserved and bit-exact repeat with the same seed.
    m = rnd_mat(1);
    do_run(1, m, 4095, 1'b1, 32'hACE1, 1'b0, "long_a");
    check_sums(1, m, last_m, "long_a.sums");
    first = last_m;
    do_run(1, m, 4095, 1'b1, 32'hACE1, 1'b0, "long_b");
    check("long_b.repeat", last_m, first);

    // Random runs on all three shapes; one uses seed 0 on load.
    for (int i = 0; i < 6; i++) begin
      k = i % 3;
      m = rnd_mat(k);
      s = (i == 4) ? 32'h0 : $urandom;
      do_run(k, m, $urandom_range(40, 1), 1'b1, s, 1'b0, $sformatf("rand%0d", i));
      check_sums(k, m, last_m, $sformatf("rand%0d.sums", i));
    end

    // Reset during the first CHECK of a 3x5 run, then an identical rerun.
    m = rnd_mat(2);
    s = 32'hBEEF;
    model_lfsr[2] = s;
    model_run(2, m, 1, tm, tsw, cyc1);
    model_lfsr[2] = s;
    model_run(2, m, 30, full_m, tsw, tcyc);
    @(negedge clk);
    mat_in[2] = m;
    num_swaps[2] = 12'd30;
    seed[2] = s;
    seed_load_v[2] = 1'b1;
    start_v[2] = 1'b1;
    @(negedge clk);
    start_v[2] = 1'b0;
    seed_load_v[2] = 1'b0;
    repeat (cyc1 - 1) @(negedge clk);
    check("rst_mid.busy", busy_v[2], 1);
    rst = 1'b1;
    #1;
    check_idle_reset(2, "rst_mid.async");
    @(negedge clk);
    check_idle_reset(2, "rst_mid.next");
    rst = 1'b0;
    reset_model();
    do_run(2, m, 30, 1'b1, s, 1'b0, "rst_rerun");
    check("rst_rerun.uninterrupted", last_m, full_m);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rect_swap_engine.md
# rect_swap_engine

Clocked, parametrised checkerboard-swap engine for binary matrices. It loads a ROWS×COLS bit matrix and runs a programmable number of random swap attempts. Each attempt picks two distinct rows and two distinct columns from an internal LFSR; if the four corners form a checkerboard unit, all four bits flip, so every row sum and column sum is preserved. The block sits under the rectangle-loop top level and replaces the untimed swap locate/swap pair with a start/done-handshaked sequential core.

## Interface
- ROWS, 4, matrix rows; 2..256
- COLS, 4, matrix columns; 2..256
- CNT_W, 12, width of the attempt and swap counters
- SEED, 32'h1, LFSR reset value; 0 is replaced by 1
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE
- num_swaps  in  CNT_W  number of swap attempts for the run
- seed_load  in  1  load `seed` into the LFSR; honoured only in IDLE
- seed  in  32  LFSR load value; 0 is replaced by 1
- mat_in  in  ROWS*COLS  input matrix, row-major; bit r*COLS+c is M[r][c]
- mat_out  out  ROWS*COLS  working matrix register, same packing
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at the end of a run
- swap_cnt  out  CNT_W  successful swaps in the last or current run

## Operation
- RW = clog2(ROWS) and CW = clog2(COLS). The build requires 2*(RW+CW) ≤ 32; elaboration fails otherwise.
- The LFSR is a 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1 (mask 32'h80200003). It shifts once per PICK cycle and at no other time.
- Index fields are taken from the LFSR's current value:
  - r1 = lfsr[RW-1:0]
  - c1 = next CW bits
  - r2 = next RW bits
  - c2 = next CW bits
- States:
  - IDLE
    - start=1 loads mat_in into the matrix register, loads the attempt counter with num_swaps, clears swap_cnt, and moves to PICK.
    - If num_swaps=0, the block goes to DONE instead of PICK.
    - seed_load=1 loads the LFSR. If seed_load and start are both high in the same cycle, the seed is loaded first and the run uses the new seed.
  - PICK
    - If r1≥ROWS, r2≥ROWS, c1≥COLS, c2≥COLS, r1==r2 or c1==c2, the draw is rejected: stay in PICK, shift the LFSR, and do not consume an attempt.
    - Otherwise latch r1, r2, c1 and c2 and move to CHECK.
  - CHECK
    - A checkerboard exists when M[r1][c1]==M[r2][c2], M[r1][c2]==M[r2][c1], and M[r1][c1]!=M[r1][c2].
    - If a checkerboard exists, invert all four bits and increment swap_cnt. swap_cnt saturates at all-ones.
    - Decrement the attempt counter. If it reaches 0, go to DONE; otherwise go to PICK.
  - DONE: drive done=1 for one cycle, then return to IDLE.
- start asserted while busy is ignored; it is neither queued nor an error.
- Row and column sums of mat_out always equal those of the loaded mat_in.

## Timing
- Reset values: matrix 0, mat_out 0, busy 0, done 0, swap_cnt 0, LFSR = SEED (1 if SEED=0), state IDLE.
- Reset asserted mid-run aborts immediately to the reset values. No done pulse is produced.
- busy goes high the cycle after start is accepted and stays high through PICK and CHECK. It is low in DONE and IDLE.
- done is high for exactly one cycle, the cycle after the final CHECK or the cycle after start when num_swaps=0. mat_out and swap_cnt are final and stable in that cycle and stay stable in IDLE.
- Each attempt takes (1 + rejected draws) PICK cycles plus 1 CHECK cycle. A run lasts at least 2*num_swaps+1 cycles from start to done.
- The matrix changes only on the load edge and on CHECK edges that perform a swap.

## Configuration
- RECT_SWAP_STATS_EN defined:
  - swap_cnt counts successful swaps as described above.
  - An internal rejected-draw counter is kept, CNT_W wide and saturating, readable only by the bench through hierarchy.
- RECT_SWAP_STATS_EN undefined:
  - swap_cnt is tied to 0 and both counters are removed.
  - Matrix behaviour and timing are identical to the defined case.

## Test plan
- ROWS=COLS=2, mat_in=4'b1001 ([[1,0],[0,1]]), num_swaps=1 → after done: mat_out=4'b0110, swap_cnt=1 (stats build), busy low.
- ROWS=COLS=2, mat_in=4'b1001, num_swaps=2 → mat_out=4'b1001, swap_cnt=2. With num_swaps=1 and mat_in=4'b1100 → mat_out unchanged, swap_cnt=0.
- 4×4 all-zero matrix, num_swaps=100 → mat_out all zero, swap_cnt=0, done exactly once, and start→done ≥ 201 cycles.
- 4×4 random matrix, num_swaps=4095, seed=32'hACE1 → every row and column sum equals mat_in's, and the run is repeatable bit-for-bit with the same seed.
- num_swaps=0 → done the cycle after start, busy never high, mat_out=mat_in. start pulsed while busy → ignored, with a single done pulse for the run.
- rst asserted during CHECK of a 3×5 run → next cycle all outputs are at reset values. The following start with the same seed reproduces the uninterrupted result.
